rand_range_picker: RTL and testbench

//  Consumer end of the 5-bit LFSR random stream. Samples the free-running random word every

---
 rtl/rand_range_picker_pkg.sv | 20 ++
 rtl/rand_pick_fifo.sv | 79 +++++++
 rtl/rand_range_picker.sv | 152 +++++++++++++++
 tb/tb_rand_range_picker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rand_range_picker_pkg.sv
// ---------------------------------------------------------------------------
// rand_pkg
// Definitions shared by the random range picker and its pick FIFO.
//   RAND_W     : width of the random word and of every pick
//   RAND_DEPTH : default number of FIFO entries
//   PTR_W      : FIFO pointer width for the default depth
//   state_t    : picker FSM states (FILL samples, HOLD waits for a pop)
// ---------------------------------------------------------------------------
package rand_pkg;

    localparam int RAND_W     = 5;
    localparam int RAND_DEPTH = 4;
    localparam int PTR_W      = $clog2(RAND_DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rand_pick_fifo.sv
// ---------------------------------------------------------------------------
// rand_pick_fifo
// Small synchronous FIFO holding accepted picks. The head entry falls through
// from storage, so a push at edge N is visible on o_head after edge N.
// When the FIFO is empty, o_head is forced to zero.
// Ports:
//   clk, RESET   : clock and synchronous active-high reset
//   i_flush      : drop all contents (same effect as reset)
//   i_push       : write i_push_data (ignored while full, never overwrites)
//   i_push_data  : value to store
//   i_pop        : remove head (ignored while empty)
//   o_valid      : FIFO non-empty
//   o_head       : oldest entry, zero when empty
//   o_count      : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module rand_pick_fifo
    import rand_pkg::*;
#(
    parameter int W     = RAND_W,
    parameter int DEPTH = RAND_DEPTH,
    parameter int AW    = PTR_W
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [W-1:0]  o_head,
    output logic [AW:0]   o_count
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (r_count != CNT_FULL);

    // Storage needs no reset: entries are only observed through r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers are AW bits wide and wrap naturally because DEPTH is 2**AW.
    always_ff @(posedge clk) begin
        if (RESET || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/rand_range_picker.sv
// ---------------------------------------------------------------------------
// rand_range_picker
// Consumer end of the LFSR random stream. Samples rnd_in every cycle while in
// FILL, keeps values below LIMIT (rejection sampling) and buffers them in
// rand_pick_fifo. After MAX_TRIES consecutive rejects a forced pick
// (rnd_in mod LIMIT) is pushed so latency stays bounded. When the FIFO fills,
// the FSM parks in HOLD until the consumer pops.
//
// Optional feature macro: RAND_NO_REPEAT_EN
//   defined   : a sample equal to the last pushed value is rejected (counts
//               as a try); a forced pick that equals the last value becomes
//               (last+1) mod LIMIT. Inactive when LIMIT==1.
//   undefined : duplicates allowed, no last-pick register.
//
// Handshake: a pick transfers on a clk edge where out_valid && out_ready;
// out_valid never depends on out_ready, and out_data holds while not taken.
//
// Ports:
//   clk, RESET    : clock and synchronous active-high reset
//   rnd_in        : random word, new value each cycle
//   flush         : discard buffered picks and restart sampling
//   out_valid     : a pick is available on out_data
//   out_ready     : consumer accepts the pick
//   out_data      : head pick (< LIMIT when valid, zero when empty)
//   buf_count     : number of buffered picks
//   o_dbg_state   : FSM state (0 = FILL, 1 = HOLD)
//   o_dbg_try     : consecutive-reject counter
// ---------------------------------------------------------------------------
module rand_range_picker
    import rand_pkg::*;
#(
    parameter int W         = RAND_W,
    parameter int LIMIT     = 20,
    parameter int DEPTH     = RAND_DEPTH,
    parameter int MAX_TRIES = 8,
    parameter int TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic [W-1:0]             rnd_in,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     o_dbg_state,
    output logic [TRY_W-1:0]         o_dbg_try
);

    localparam int          AW       = $clog2(DEPTH);
    // LIMIT may equal 2**W, so comparisons use one extra bit.
    localparam logic [W:0]  LIM      = (W+1)'(LIMIT);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [AW:0] CNT_NEAR = (AW+1)'(DEPTH - 1);

    state_t             r_state;
    logic [TRY_W-1:0]   r_try;

    logic               w_pop;
    logic               w_in_range;
    logic [W-1:0]       w_mod;
    logic               w_accept;
    logic [W-1:0]       w_forced;
    logic               w_sample;
    logic               w_force;
    logic               w_push;
    logic [W-1:0]       w_push_data;

    assign w_pop      = out_valid && out_ready;
    assign w_in_range = ({1'b0, rnd_in} < LIM);
    // Constant divisor: synthesis reduces this to fixed combinational logic.
    assign w_mod      = W'({1'b0, rnd_in} % LIM);

`ifdef RAND_NO_REPEAT_EN
    localparam logic NR_ACTIVE = (LIMIT > 1);

    logic [W-1:0] r_last;
    logic         r_last_valid;
    logic         w_dup;

    assign w_dup    = NR_ACTIVE && r_last_valid && (rnd_in == r_last);
    assign w_accept = w_in_range && !w_dup;
    assign w_forced = (NR_ACTIVE && r_last_valid && (w_mod == r_last))
                      ? W'(({1'b0, r_last} + 1'b1) % LIM)
                      : w_mod;

    always_ff @(posedge clk) begin
        if (RESET || flush) begin
            r_last       <= '0;
            r_last_valid <= 1'b0;
        end else if (w_push) begin
            r_last       <= w_push_data;
            r_last_valid <= 1'b1;
        end
    end
`else
    assign w_accept = w_in_range;
    assign w_forced = w_mod;
`endif

    // Sampling happens only in FILL; in HOLD rnd_in is ignored and try frozen.
    assign w_sample    = (r_state == FILL);
    assign w_force     = w_sample && !w_accept && (r_try == TRY_LAST);
    assign w_push      = w_sample && (w_accept || w_force);
    assign w_push_data = w_accept ? rnd_in : w_forced;

    always_ff @(posedge clk) begin
        if (RESET || flush) begin
            r_state <= FILL;
            r_try   <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept || w_force) begin
                        r_try <= '0;
                    end else begin
                        r_try <= r_try + 1'b1;
                    end
                    // The push that brings the FIFO to DEPTH parks the FSM.
                    if (w_push && !w_pop && (buf_count == CNT_NEAR)) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_pop) begin
                        r_state <= FILL;
                    end
                end
            endcase
        end
    end

    rand_pick_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .RESET       (RESET),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_valid     (out_valid),
        .o_head      (out_data),
        .o_count     (buf_count)
    );

    assign o_dbg_state = r_state;
    assign o_dbg_try   = r_try;

endmodule

// File: tb/tb_rand_range_picker.sv
module tb_rand_range_picker;

    localparam int W         = 5;
    localparam int LIMIT     = 20;
    localparam int DEPTH     = 4;
    localparam int MAX_TRIES = 8;
    localparam int TRY_W     = $clog2(MAX_TRIES + 1);
    localparam int CW        = $clog2(DEPTH) + 1;

    logic             clk;
    logic             RESET;
    logic [W-1:0]     rnd_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CW-1:0]    buf_count;
    logic             o_dbg_state;
    logic [TRY_W-1:0] o_dbg_try;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: list of buffered picks plus the sampler's bookkeeping.
    int mq[$];
    int m_try;
    bit m_hold;
    int m_last;
    bit m_last_v;

    rand_range_picker #(
        .W         (W),
        .LIMIT     (LIMIT),
        .DEPTH     (DEPTH),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .rnd_in      (rnd_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .buf_count   (buf_count),
        .o_dbg_state (o_dbg_state),
        .o_dbg_try   (o_dbg_try)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level behaviour for one clock edge.
    task automatic model_step(input int rnd, input bit rdy, input bit fl, input bit rst);
        bit pop;
        bit ok;
        bit do_push;
        int val;
        int forced;
        if (rst || fl) begin
            mq.delete();
            m_try    = 0;
            m_hold   = 0;
            m_last   = 0;
            m_last_v = 0;
            return;
        end
        pop     = (mq.size() > 0) && rdy;
        do_push = 0;
        val     = 0;
        if (!m_hold) begin
            ok = (rnd < LIMIT);
`ifdef RAND_NO_REPEAT_EN
            if (LIMIT > 1 && m_last_v && rnd == m_last) ok = 0;
`endif
            if (ok) begin
                do_push = 1;
                val     = rnd;
                m_try   = 0;
            end else if (m_try + 1 == MAX_TRIES) begin
                forced = rnd % LIMIT;
`ifdef RAND_NO_REPEAT_EN
                if (LIMIT > 1 && m_last_v && forced == m_last) forced = (m_last + 1) % LIMIT;
`endif
                do_push = 1;
                val     = forced;
                m_try   = 0;
            end else begin
                m_try = m_try + 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (do_push && mq.size() < DEPTH) begin
            mq.push_back(val);
            m_last   = val;
            m_last_v = 1;
        end
        if (m_hold && pop) m_hold = 0;
        else if (!m_hold && mq.size() == DEPTH) m_hold = 1;
    endtask

    // Scoreboard compare, run on the falling edge after every active edge.
    task automatic compare_all();
        chk("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
        chk("out_data", int'(out_data), (mq.size() != 0) ? mq[0] : 0);
        chk("buf_count", int'(buf_count), mq.size());
        chk("state", int'(o_dbg_state), int'(m_hold));
        chk("try", int'(o_dbg_try), m_try);
    endtask

    // Driver: one clock cycle with the given inputs.
    task automatic cyc(input int rnd, input bit rdy, input bit fl = 1'b0, input bit rst = 1'b0);
        rnd_in    = W'(rnd);
        out_ready = rdy;
        flush     = fl;
        RESET     = rst;
        @(posedge clk);
        model_step(rnd, rdy, fl, rst);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rnd_in    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        RESET     = 1'b1;
        @(negedge clk);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        // Reset state, literal
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_count", int'(buf_count), 0);
        chk("rst_data", int'(out_data), 0);

        // 1: in-range values pass, 25 is dropped
        cyc(3, 1);
        chk("t1_first", int'(out_data), 3);
        cyc(25, 1);
        chk("t1_drop", int'(buf_count), 0);
        cyc(7, 1);
        chk("t1_second", int'(out_data), 7);

        // 2: eight rejects in a row force 31 mod 20 = 11
        for (int i = 0; i < 7; i++) begin
            cyc(31, 1);
            chk("t2_nopush", int'(buf_count), 0);
        end
        cyc(31, 1);
        chk("t2_forced", int'(out_data), 11);
        chk("t2_forced_cnt", int'(buf_count), 1);

        // 3: fill to DEPTH, park in HOLD, resume after a pop
        cyc(0, 0, 1);
        for (int v = 1; v <= 5; v++) cyc(v, 0);
        chk("t3_full", int'(buf_count), 4);
        chk("t3_hold", int'(o_dbg_state), 1);
        chk("t3_head", int'(out_data), 1);
        cyc(9, 1);
        chk("t3_pop_head", int'(out_data), 2);
        chk("t3_pop_cnt", int'(buf_count), 3);
        chk("t3_fill", int'(o_dbg_state), 0);
        cyc(10, 0);
        chk("t3_resume", int'(buf_count), 4);

        // 4: flush wins over a valid sample
        cyc(0, 0, 1);
        cyc(1, 0);
        cyc(2, 0);
        chk("t4_two", int'(buf_count), 2);
        cyc(9, 0, 1);
        chk("t4_flush_cnt", int'(buf_count), 0);
        chk("t4_flush_valid", int'(out_valid), 0);

        // 5: reset mid-operation with count 3 and try 5
        cyc(1, 0);
        cyc(2, 0);
        cyc(3, 0);
        for (int i = 0; i < 5; i++) cyc(31, 0);
        chk("t5_pre_cnt", int'(buf_count), 3);
        chk("t5_pre_try", int'(o_dbg_try), 5);
        cyc(0, 0, 0, 1);
        chk("t5_rst_cnt", int'(buf_count), 0);
        chk("t5_rst_try", int'(o_dbg_try), 0);
        chk("t5_rst_data", int'(out_data), 0);
        cyc(4, 0);
        chk("t5_first", int'(out_data), 4);
        chk("t5_first_v", int'(out_valid), 1);

`ifdef RAND_NO_REPEAT_EN
        // 6: repeats rejected, forced pick steps past the last value
        cyc(0, 0, 1);
        cyc(5, 0);
        cyc(5, 0);
        cyc(6, 0);
        chk("t6_cnt", int'(buf_count), 2);
        chk("t6_head", int'(out_data), 5);
        cyc(0, 0, 1);
        cyc(5, 0);
        for (int i = 0; i < 7; i++) cyc(25, 0);
        chk("t6_wait", int'(buf_count), 1);
        cyc(25, 0);
        chk("t6_forced_cnt", int'(buf_count), 2);
        cyc(25, 1);
        chk("t6_forced", int'(out_data), 6);
`endif

        // Mixed traffic, checked every cycle against the model
        cyc(0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            cyc(int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
